writeback_unit: RTL and testbench
=================================

# writeback_unit

Final (WB) stage of the 5-stage pipeline; consumes the results the memory unit produces. It latches the memory stage's result into a MEM/WB register and selects the load data or the ALU result by opcode. It commits that value to a 16×16 register file one cycle later, with two bypassed read ports for the decode stage. It also tracks the retired-instruction count and the halt state.

## Interface
Parameters:
- DW, 16, datapath width
- NREG, 16, register count (address width 4)

Ports:
- clkwire  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- memvalid  in  1  memory stage presents a valid instruction this cycle
- instruction  in  4  opcode of the instruction leaving MEM
- linenum  in  4  program line of that instruction
- registernum  in  4  destination register
- writedata  in  DW  load data from data memory
- aluoutput  in  DW  ALU result forwarded through MEM
- rs1addr, rs2addr  in  4  decode-stage read addresses
- rs1data, rs2data  out  DW  read data, combinational, bypassed
- wb_valid  out  1  MEM/WB register holds a committing instruction
- wb_regnum  out  4  destination being committed
- wb_data  out  DW  value being committed
- wb_linenum  out  4  line being retired
- retired  out  16  retired-instruction counter
- halted  out  1  halt instruction retired

## Operation
- Opcode classes:
  - 0011 LOAD: source is writedata; writes the register file.
  - 0100 STORE: no register write; retires.
  - 1110 NOP: no write; does not retire.
  - 1111 HALT: no write; retires; sets halted.
  - All other opcodes: ALU ops; source is aluoutput; write the register file.
- Capture: on an edge with memvalid=1, halted=0, and an opcode other than NOP, the MEM/WB register loads:
  - wb_valid=1;
  - wb_regnum=registernum;
  - wb_linenum=linenum;
  - wb_data = the selected source (0 for STORE and HALT);
  - an internal wen = writes-class AND registernum≠0.
- On any other edge, wb_valid=0 and wen=0. The other fields hold their previous values.
- Commit: on the edge after capture, if wen=1, regfile[wb_regnum] ← wb_data.
- R0 always reads 0. Writes to R0 are dropped, but still retire.
- Reads: rsXdata = 0 if rsXaddr=0. Otherwise, if wen=1 and wb_regnum=rsXaddr, rsXdata = wb_data (bypass). Otherwise rsXdata = regfile[rsXaddr].
- Retire counter: increments by 1 on every capture edge, including STORE and HALT. Wraps 0xFFFF→0x0000.
- Halt FSM, two states:
  - RUN → HALTED on capture of HALT.
  - HALTED is absorbing until rst. In HALTED, memvalid is ignored, no captures occur, and the counter is frozen.
  - A commit pending from the HALT's predecessor still completes.
- Reset: every register file entry = 0, wb_valid=0, wen=0, wb_regnum=0, wb_data=0, wb_linenum=0, retired=0, halted=0.
  - A pending commit at reset is discarded.
  - Reset has priority over a simultaneous capture.

## Timing
- Capture latency: inputs sampled at edge E → wb_* and retired valid after E.
- Commit latency: the register file is updated at E+1. Decode sees the new value via bypass during E..E+1, and from the array after E+1.
- Back-to-back writes to the same register on consecutive edges: the younger value wins. Bypass always reflects the MEM/WB register, never a stale array entry.
- Both read ports may address the same register; they return identical data.
- halted rises after the edge that captures HALT. retired includes the HALT.

## Test plan
- Reset then idle: rst=1 for 2 edges with memvalid=1 → all outputs 0, rs1data=rs2data=0 for every address.
- LOAD: memvalid=1, instruction=0011, registernum=6, writedata=0x1234, aluoutput=0x0004, linenum=9 →
  - after E: wb_valid=1, wb_data=0x1234, wb_regnum=6, wb_linenum=9, retired=1;
  - rs1addr=6 gives 0x1234 via bypass before E+1, and from the array after.
- ALU back-to-back: opcode 0001 writes R3=0x0004, then opcode 0010 writes R3=0x00AA on the next edge → rs2addr=3 reads 0x0004 then 0x00AA, final array R3=0x00AA, retired=2.
- R0 and STORE: opcode 0001 with registernum=0 and aluoutput=0xFFFF, then STORE 0100 with registernum=5 → R0 reads 0, R5 unchanged at 0, retired=2.
- Halt:
  - HALT captured, then ALU writes with memvalid=1 for 3 edges → halted=1, retired frozen, no further register changes;
  - rst then clears halted and retired.
- Wrap and reset mid-commit:
  - preload retired=0xFFFF via 65535 captures, one more capture → retired=0x0000;
  - capture a LOAD to R7 and assert rst at the next edge → R7 stays 0.

Source files
------------

// File: rtl/writeback_unit.sv
// Writeback stage: MEM/WB register, a 16x16 register file with two bypassed
// read ports, a retired-instruction counter and a two-state halt machine.
module writeback_unit #(
    parameter int DW   = 16,
    parameter int NREG = 16
) (
    input  logic          clkwire,
    input  logic          rst,
    input  logic          memvalid,
    input  logic [3:0]    instruction,
    input  logic [3:0]    linenum,
    input  logic [3:0]    registernum,
    input  logic [DW-1:0] writedata,
    input  logic [DW-1:0] aluoutput,
    input  logic [3:0]    rs1addr,
    input  logic [3:0]    rs2addr,
    output logic [DW-1:0] rs1data,
    output logic [DW-1:0] rs2data,
    output logic          wb_valid,
    output logic [3:0]    wb_regnum,
    output logic [DW-1:0] wb_data,
    output logic [3:0]    wb_linenum,
    output logic [15:0]   retired,
    output logic          halted
);

    localparam logic [3:0] OP_LOAD  = 4'b0011;
    localparam logic [3:0] OP_STORE = 4'b0100;
    localparam logic [3:0] OP_NOP   = 4'b1110;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t        state;
    logic          wen;
    logic [DW-1:0] regfile [NREG];

    logic          is_load;
    logic          is_store;
    logic          is_nop;
    logic          is_halt;
    logic          capture;
    logic          writes_rf;
    logic [DW-1:0] sel_data;

    always_comb begin
        is_load   = (instruction == OP_LOAD);
        is_store  = (instruction == OP_STORE);
        is_nop    = (instruction == OP_NOP);
        is_halt   = (instruction == OP_HALT);
        capture   = memvalid && (state == ST_RUN) && !is_nop;
        writes_rf = !is_store && !is_halt && !is_nop;
        sel_data  = '0;
        if (is_load) begin
            sel_data = writedata;
        end else if (writes_rf) begin
            sel_data = aluoutput;
        end
    end

    // The commit of the previous capture and the next capture share an edge;
    // reset wins over both, so a pending commit at reset is dropped.
    always_ff @(posedge clkwire) begin
        if (rst) begin
            state      <= ST_RUN;
            halted     <= 1'b0;
            wb_valid   <= 1'b0;
            wen        <= 1'b0;
            wb_regnum  <= '0;
            wb_data    <= '0;
            wb_linenum <= '0;
            retired    <= '0;
            for (int i = 0; i < NREG; i++) begin
                regfile[i] <= '0;
            end
        end else begin
            if (wen) begin
                regfile[wb_regnum] <= wb_data;
            end
            wb_valid <= capture;
            wen      <= capture && writes_rf && (registernum != 4'd0);
            if (capture) begin
                wb_regnum  <= registernum;
                wb_linenum <= linenum;
                wb_data    <= sel_data;
                retired    <= retired + 16'd1;
                if (is_halt) begin
                    state  <= ST_HALTED;
                    halted <= 1'b1;
                end
            end
        end
    end

    // Bypass from MEM/WB so decode never sees a stale array entry.
    always_comb begin
        rs1data = '0;
        if (rs1addr != 4'd0) begin
            if (wen && (wb_regnum == rs1addr)) begin
                rs1data = wb_data;
            end else begin
                rs1data = regfile[rs1addr];
            end
        end
    end

    always_comb begin
        rs2data = '0;
        if (rs2addr != 4'd0) begin
            if (wen && (wb_regnum == rs2addr)) begin
                rs2data = wb_data;
            end else begin
                rs2data = regfile[rs2addr];
            end
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit: reset, LOAD bypass/commit,
// ALU back-to-back, R0/STORE, NOP hold, halt freeze, counter wrap, reset mid-commit.
module tb_writeback_unit;

    logic        clkwire;
    logic        rst;
    logic        memvalid;
    logic [3:0]  instruction;
    logic [3:0]  linenum;
    logic [3:0]  registernum;
    logic [15:0] writedata;
    logic [15:0] aluoutput;
    logic [3:0]  rs1addr;
    logic [3:0]  rs2addr;
    logic [15:0] rs1data;
    logic [15:0] rs2data;
    logic        wb_valid;
    logic [3:0]  wb_regnum;
    logic [15:0] wb_data;
    logic [3:0]  wb_linenum;
    logic [15:0] retired;
    logic        halted;

    int checks;
    int failures;

    writeback_unit #(.DW(16), .NREG(16)) dut (
        .clkwire    (clkwire),
        .rst        (rst),
        .memvalid   (memvalid),
        .instruction(instruction),
        .linenum    (linenum),
        .registernum(registernum),
        .writedata  (writedata),
        .aluoutput  (aluoutput),
        .rs1addr    (rs1addr),
        .rs2addr    (rs2addr),
        .rs1data    (rs1data),
        .rs2data    (rs2data),
        .wb_valid   (wb_valid),
        .wb_regnum  (wb_regnum),
        .wb_data    (wb_data),
        .wb_linenum (wb_linenum),
        .retired    (retired),
        .halted     (halted)
    );

    initial clkwire = 1'b0;
    always #5 clkwire = ~clkwire;

    task automatic tick();
        @(posedge clkwire);
        #1;
    endtask

    task automatic drive(input logic mv, input logic [3:0] op, input logic [3:0] rn,
                         input logic [15:0] wd, input logic [15:0] ao, input logic [3:0] ln);
        memvalid    = mv;
        instruction = op;
        registernum = rn;
        writedata   = wd;
        aluoutput   = ao;
        linenum     = ln;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 4'b1110, 4'd0, 16'h0, 16'h0, 4'd0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 4'b0011, 4'd5, 16'hDEAD, 16'hBEEF, 4'd3);
        tick();
        tick();
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%0b exp=0", wb_valid); end
        checks++; if (wb_regnum !== 4'd0) begin failures++; $display("FAIL reset_wb_regnum got=%0h exp=0", wb_regnum); end
        checks++; if (wb_data !== 16'h0) begin failures++; $display("FAIL reset_wb_data got=%0h exp=0", wb_data); end
        checks++; if (wb_linenum !== 4'd0) begin failures++; $display("FAIL reset_wb_linenum got=%0h exp=0", wb_linenum); end
        checks++; if (retired !== 16'h0) begin failures++; $display("FAIL reset_retired got=%0h exp=0", retired); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%0b exp=0", halted); end
        for (int a = 0; a < 16; a++) begin
            rs1addr = 4'(a);
            rs2addr = 4'(15 - a);
            #1;
            checks++; if (rs1data !== 16'h0) begin failures++; $display("FAIL reset_rs1 addr=%0d got=%0h exp=0", a, rs1data); end
            checks++; if (rs2data !== 16'h0) begin failures++; $display("FAIL reset_rs2 addr=%0d got=%0h exp=0", 15 - a, rs2data); end
        end
        rst = 1'b0;
        drive(1'b0, 4'b1110, 4'd0, 16'h0, 16'h0, 4'd0);
    endtask

    task automatic test_load();
        do_reset();
        drive(1'b1, 4'b0011, 4'd6, 16'h1234, 16'h0004, 4'd9);
        tick();
        drive(1'b0, 4'b1110, 4'd0, 16'h0, 16'h0, 4'd0);
        rs1addr = 4'd6;
        #1;
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL load_wb_valid got=%0b exp=1", wb_valid); end
        checks++; if (wb_data !== 16'h1234) begin failures++; $display("FAIL load_wb_data got=%0h exp=1234", wb_data); end
        checks++; if (wb_regnum !== 4'd6) begin failures++; $display("FAIL load_wb_regnum got=%0d exp=6", wb_regnum); end
        checks++; if (wb_linenum !== 4'd9) begin failures++; $display("FAIL load_wb_linenum got=%0d exp=9", wb_linenum); end
        checks++; if (retired !== 16'd1) begin failures++; $display("FAIL load_retired got=%0h exp=1", retired); end
        checks++; if (rs1data !== 16'h1234) begin failures++; $display("FAIL load_bypass got=%0h exp=1234", rs1data); end
        tick();
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL load_wb_valid_drop got=%0b exp=0", wb_valid); end
        checks++; if (rs1data !== 16'h1234) begin failures++; $display("FAIL load_array got=%0h exp=1234", rs1data); end
        tick();
        checks++; if (rs1data !== 16'h1234) begin failures++; $display("FAIL load_array_hold got=%0h exp=1234", rs1data); end
    endtask

    task automatic test_alu_back_to_back();
        do_reset();
        rs1addr = 4'd3;
        rs2addr = 4'd3;
        drive(1'b1, 4'b0001, 4'd3, 16'h7777, 16'h0004, 4'd1);
        tick();
        checks++; if (rs2data !== 16'h0004) begin failures++; $display("FAIL b2b_first got=%0h exp=0004", rs2data); end
        drive(1'b1, 4'b0010, 4'd3, 16'h7777, 16'h00AA, 4'd2);
        tick();
        drive(1'b0, 4'b1110, 4'd0, 16'h0, 16'h0, 4'd0);
        #1;
        checks++; if (rs2data !== 16'h00AA) begin failures++; $display("FAIL b2b_second_bypass got=%0h exp=00AA", rs2data); end
        checks++; if (rs1data !== 16'h00AA) begin failures++; $display("FAIL b2b_port1_same got=%0h exp=00AA", rs1data); end
        tick();
        checks++; if (rs2data !== 16'h00AA) begin failures++; $display("FAIL b2b_final_array got=%0h exp=00AA", rs2data); end
        checks++; if (retired !== 16'd2) begin failures++; $display("FAIL b2b_retired got=%0h exp=2", retired); end
    endtask

    task automatic test_r0_store();
        do_reset();
        rs1addr = 4'd0;
        rs2addr = 4'd5;
        drive(1'b1, 4'b0001, 4'd0, 16'h0000, 16'hFFFF, 4'd4);
        tick();
        checks++; if (wb_data !== 16'hFFFF) begin failures++; $display("FAIL r0_wb_data got=%0h exp=FFFF", wb_data); end
        checks++; if (rs1data !== 16'h0) begin failures++; $display("FAIL r0_bypass got=%0h exp=0", rs1data); end
        drive(1'b1, 4'b0100, 4'd5, 16'h0066, 16'h0055, 4'd5);
        tick();
        drive(1'b0, 4'b1110, 4'd0, 16'h0, 16'h0, 4'd0);
        #1;
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL store_wb_valid got=%0b exp=1", wb_valid); end
        checks++; if (wb_data !== 16'h0) begin failures++; $display("FAIL store_wb_data got=%0h exp=0", wb_data); end
        tick();
        tick();
        checks++; if (rs1data !== 16'h0) begin failures++; $display("FAIL r0_array got=%0h exp=0", rs1data); end
        checks++; if (rs2data !== 16'h0) begin failures++; $display("FAIL store_r5 got=%0h exp=0", rs2data); end
        checks++; if (retired !== 16'd2) begin failures++; $display("FAIL r0_store_retired got=%0h exp=2", retired); end
    endtask

    task automatic test_nop_hold();
        do_reset();
        drive(1'b1, 4'b0001, 4'd9, 16'h0, 16'h0321, 4'd11);
        tick();
        drive(1'b1, 4'b1110, 4'd2, 16'h1111, 16'h2222, 4'd12);
        tick();
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL nop_wb_valid got=%0b exp=0", wb_valid); end
        checks++; if (wb_regnum !== 4'd9) begin failures++; $display("FAIL nop_hold_regnum got=%0d exp=9", wb_regnum); end
        checks++; if (wb_data !== 16'h0321) begin failures++; $display("FAIL nop_hold_data got=%0h exp=0321", wb_data); end
        checks++; if (wb_linenum !== 4'd11) begin failures++; $display("FAIL nop_hold_linenum got=%0d exp=11", wb_linenum); end
        checks++; if (retired !== 16'd1) begin failures++; $display("FAIL nop_retired got=%0h exp=1", retired); end
        drive(1'b0, 4'b0001, 4'd2, 16'h0, 16'h4444, 4'd13);
        tick();
        rs1addr = 4'd2;
        rs2addr = 4'd9;
        #1;
        checks++; if (retired !== 16'd1) begin failures++; $display("FAIL idle_retired got=%0h exp=1", retired); end
        checks++; if (rs1data !== 16'h0) begin failures++; $display("FAIL idle_no_write got=%0h exp=0", rs1data); end
        checks++; if (rs2data !== 16'h0321) begin failures++; $display("FAIL nop_r9 got=%0h exp=0321", rs2data); end
    endtask

    task automatic test_halt();
        do_reset();
        rs1addr = 4'd2;
        rs2addr = 4'd4;
        drive(1'b1, 4'b0001, 4'd2, 16'h0, 16'h0011, 4'd1);
        tick();
        drive(1'b1, 4'b1111, 4'd3, 16'h0, 16'h0, 4'd2);
        tick();
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_set got=%0b exp=1", halted); end
        checks++; if (retired !== 16'd2) begin failures++; $display("FAIL halt_retired got=%0h exp=2", retired); end
        checks++; if (wb_data !== 16'h0) begin failures++; $display("FAIL halt_wb_data got=%0h exp=0", wb_data); end
        drive(1'b1, 4'b0001, 4'd2, 16'h0, 16'h0099, 4'd3);
        tick();
        drive(1'b1, 4'b0010, 4'd4, 16'h0, 16'h0088, 4'd4);
        tick();
        drive(1'b1, 4'b0011, 4'd4, 16'h0077, 16'h0, 4'd5);
        tick();
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_absorb got=%0b exp=1", halted); end
        checks++; if (retired !== 16'd2) begin failures++; $display("FAIL halt_frozen got=%0h exp=2", retired); end
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL halt_no_capture got=%0b exp=0", wb_valid); end
        checks++; if (rs1data !== 16'h0011) begin failures++; $display("FAIL halt_pred_commit got=%0h exp=0011", rs1data); end
        checks++; if (rs2data !== 16'h0) begin failures++; $display("FAIL halt_no_write got=%0h exp=0", rs2data); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 4'b1110, 4'd0, 16'h0, 16'h0, 4'd0);
        #1;
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_clear got=%0b exp=0", halted); end
        checks++; if (retired !== 16'd0) begin failures++; $display("FAIL halt_retired_clear got=%0h exp=0", retired); end
    endtask

    task automatic test_wrap_and_reset_commit();
        do_reset();
        drive(1'b1, 4'b0001, 4'd1, 16'h0, 16'h0101, 4'd0);
        repeat (65535) @(posedge clkwire);
        #1;
        checks++; if (retired !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload got=%0h exp=FFFF", retired); end
        tick();
        checks++; if (retired !== 16'h0000) begin failures++; $display("FAIL wrap_zero got=%0h exp=0", retired); end
        drive(1'b1, 4'b0011, 4'd7, 16'hBEEF, 16'h0, 4'd6);
        tick();
        checks++; if (wb_data !== 16'hBEEF) begin failures++; $display("FAIL midrst_capture got=%0h exp=BEEF", wb_data); end
        rst = 1'b1;
        drive(1'b0, 4'b1110, 4'd0, 16'h0, 16'h0, 4'd0);
        tick();
        rst = 1'b0;
        rs1addr = 4'd7;
        rs2addr = 4'd1;
        #1;
        checks++; if (rs1data !== 16'h0) begin failures++; $display("FAIL midrst_r7 got=%0h exp=0", rs1data); end
        checks++; if (rs2data !== 16'h0) begin failures++; $display("FAIL midrst_r1_cleared got=%0h exp=0", rs2data); end
        tick();
        checks++; if (rs1data !== 16'h0) begin failures++; $display("FAIL midrst_r7_later got=%0h exp=0", rs1data); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rs1addr  = 4'd0;
        rs2addr  = 4'd0;
        test_reset();
        test_load();
        test_alu_back_to_back();
        test_r0_store();
        test_nop_hold();
        test_halt();
        test_wrap_and_reset_commit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
